// File: rtl/dmem_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dmem_arb_pkg
// Description : Shared constants for the data-memory access arbiter:
//               FSM state encoding, requester port indices and a one-hot
//               helper used by the arbiter and the top level.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

  // FSM state encoding (2 bits)
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Requester port indices
  localparam int unsigned PORT_CPU = 0;  // CPU load/store unit
  localparam int unsigned PORT_LDR = 1;  // program/debug loader

  // Convert a 1-bit port index into a 2-bit one-hot vector
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input combinational arbiter. Round-robin by default
//               (the port that did not win last time wins a contention);
//               fixed priority to port 0 when FIXED_PRIO != 0.
// Ports       : i_req[1:0]  per-port request
//               i_last      index of the port that won the previous grant
//               o_win_oh    one-hot winner (0 when nobody requests)
//               o_win_idx   winner index (meaningful only when |i_req)
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
  import dmem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win_oh,
  output logic       o_win_idx
);

  generate
    if (FIXED_PRIO != 0) begin : g_fixed
      // Port 0 wins whenever it asks; port 1 only when alone.
      assign o_win_idx = ~i_req[0] & i_req[1];
      // History is irrelevant with fixed priority.
      logic w_unused_last;
      assign w_unused_last = i_last;
    end else begin : g_rr
      // Contention goes to the port that did not win last; a lone
      // requester wins regardless of history.
      assign o_win_idx = (&i_req) ? ~i_last : i_req[1];
    end
  endgenerate

  assign o_win_oh = (i_req == 2'b00) ? 2'b00 : port_onehot(o_win_idx);

endmodule
`default_nettype wire

// File: rtl/dmem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_arbiter
// Description : Shares one single-port data memory between the CPU
//               load/store unit (port 0) and the program/debug loader
//               (port 1). Each transaction is IDLE/RESP -> ACCESS -> RESP:
//               requests are sampled in IDLE or RESP, the memory is driven
//               during ACCESS, and the captured read data is returned with
//               rvalid in RESP. Back-to-back throughput is one access per
//               two cycles.
// Ports       : clk, reset              clock, asynchronous active-high reset
//               i_req[1:0], i_we[1:0]   per-port request / write enable
//               i_addr0/1, i_wdata0/1   per-port word address / store data
//               o_gnt[1:0]              one-hot, access on memory this cycle
//               o_rvalid[1:0]           one-hot, o_rdata/o_rerr valid
//               o_rdata, o_rerr         read data (old contents on store),
//                                       out-of-range flag
//               o_mem_we/addr/wdata     memory MemWrite/Address/StoreData
//               i_mem_rdata             memory ReadData (combinational)
// Revision    : 1.0  initial release
// ============================================================================
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int          FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [31:0]       i_wdata0,
  input  logic [31:0]       i_wdata1,
  output logic [1:0]        o_gnt,
  output logic [1:0]        o_rvalid,
  output logic [31:0]       o_rdata,
  output logic              o_rerr,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  logic [1:0]        r_state;
  logic              r_last;    // index of the most recent winner
  logic              r_win;     // winner of the transaction in flight
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_rerr;

  logic [1:0]        w_win_oh;
  logic              w_win_idx;
  logic              w_sample;
  logic              w_access;
  logic              w_in_range;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .i_req     (i_req),
    .i_last    (r_last),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx)
  );

  assign w_sample   = (r_state == IDLE) || (r_state == RESP);
  assign w_access   = (r_state == ACCESS);
  assign w_in_range = (32'(r_addr) < DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'(PORT_LDR);  // so the CPU port wins the first contention
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          if (w_sample && (i_req != 2'b00)) begin
            r_state <= ACCESS;
            r_win   <= w_win_idx;
            r_last  <= w_win_idx;
            r_we    <= |(i_we & w_win_oh);
            r_addr  <= w_win_idx ? i_addr1  : i_addr0;
            r_wdata <= w_win_idx ? i_wdata1 : i_wdata0;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          // Read data is captured on the same edge a store commits, so a
          // store returns the pre-write contents.
          r_rdata <= w_in_range ? i_mem_rdata : 32'h0;
          r_rerr  <= ~w_in_range;
          r_state <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory-side strobes are decoded from state only, so an asynchronous
  // reset removes the write enable immediately.
  assign o_gnt       = w_access ? port_onehot(r_win) : 2'b00;
  assign o_rvalid    = (r_state == RESP) ? port_onehot(r_win) : 2'b00;
  assign o_mem_we    = w_access & r_we & w_in_range;
  assign o_mem_addr  = w_access ? r_addr  : '0;
  assign o_mem_wdata = w_access ? r_wdata : 32'h0;
  assign o_rdata     = r_rdata;
  assign o_rerr      = r_rerr;

endmodule
`default_nettype wire
